// File: rtl/stall_flush_ctrl.sv
// stall_flush_ctrl: pipeline hazard controller for load-use bubbles, redirect flushes, memory freezes and stall counting
module stall_flush_ctrl #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int LU_STALL_CYCLES   = 1,
  parameter int BR_FLUSH_CYCLES   = 1,
  parameter int CNT_W             = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_DATA_LENGTH-1:0] Inst,
  input  logic [4:0]                   Rd_EX,
  input  logic                         MemRead_EX,
  input  logic                         Br_Detected,
  input  logic [1:0]                   Br_result,
  input  logic                         Dmem_Busy,
  input  logic                         Perf_Clr,
  output logic                         PC_Fetch_EN,
  output logic                         FE_DE_Reg_EN,
  output logic                         DE_EX_Reg_EN,
  output logic                         EX_MEM_Reg_EN,
  output logic                         FE_DE_Reg_RST,
  output logic                         DE_EX_Reg_RST,
  output logic                         Stall_Detected,
  output logic                         Flush_Detected,
  output logic [CNT_W-1:0]             Stall_Count
);
  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;
  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [6:0] op;
  logic uses_rs1, uses_rs2, haz, redir, unused_bits;
  assign op          = Inst[6:0];
  assign uses_rs1    = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  assign uses_rs2    = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  assign haz         = MemRead_EX && Rd_EX != 5'd0 &&
                       ((uses_rs1 && Inst[19:15] == Rd_EX) || (uses_rs2 && Inst[24:20] == Rd_EX));
  assign redir       = Br_Detected && Br_result != 2'b00;
  assign unused_bits = ^{Inst[WIDTH_DATA_LENGTH-1:25], Inst[14:7]};
  // state and bubble/flush down-counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  // next state and Mealy outputs: freeze > redirect > flush/load-use; reset forces outputs
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    PC_Fetch_EN    = 1'b1;
    FE_DE_Reg_EN   = 1'b1;
    DE_EX_Reg_EN   = 1'b1;
    EX_MEM_Reg_EN  = 1'b1;
    FE_DE_Reg_RST  = 1'b0;
    DE_EX_Reg_RST  = 1'b0;
    Stall_Detected = 1'b0;
    Flush_Detected = 1'b0;
    if (Dmem_Busy) begin
      PC_Fetch_EN    = 1'b0;
      FE_DE_Reg_EN   = 1'b0;
      DE_EX_Reg_EN   = 1'b0;
      EX_MEM_Reg_EN  = 1'b0;
      Stall_Detected = 1'b1;
    end else if (redir) begin
      FE_DE_Reg_RST  = 1'b1;
      DE_EX_Reg_RST  = 1'b1;
      Flush_Detected = 1'b1;
      state_nxt      = BR_FLUSH_CYCLES > 1 ? FLUSH : RUN;
      cnt_nxt        = BR_FLUSH_CYCLES > 1 ? 3'(BR_FLUSH_CYCLES - 1) : cnt;
    end else if (state == FLUSH) begin
      FE_DE_Reg_RST  = 1'b1;
      Flush_Detected = 1'b1;
      cnt_nxt        = cnt - 3'd1;
      state_nxt      = cnt == 3'd1 ? RUN : FLUSH;
    end else if (state == LU_STALL || haz) begin
      PC_Fetch_EN    = 1'b0;
      FE_DE_Reg_EN   = 1'b0;
      DE_EX_Reg_RST  = 1'b1;
      Stall_Detected = 1'b1;
      if (state == LU_STALL) begin
        cnt_nxt   = cnt - 3'd1;
        state_nxt = cnt == 3'd1 ? RUN : LU_STALL;
      end else if (LU_STALL_CYCLES > 1) begin
        cnt_nxt   = 3'(LU_STALL_CYCLES - 1);
        state_nxt = LU_STALL;
      end
    end
    if (rst) begin
      PC_Fetch_EN    = 1'b0;
      FE_DE_Reg_EN   = 1'b0;
      DE_EX_Reg_EN   = 1'b0;
      EX_MEM_Reg_EN  = 1'b0;
      FE_DE_Reg_RST  = 1'b1;
      DE_EX_Reg_RST  = 1'b1;
      Stall_Detected = 1'b0;
      Flush_Detected = 1'b0;
    end
  end
  // saturating stall-cycle counter, clear beats increment
  always_ff @(posedge clk or posedge rst)
    if (rst) Stall_Count <= '0;
    else if (Perf_Clr) Stall_Count <= '0;
    else if (Stall_Detected && !(&Stall_Count)) Stall_Count <= Stall_Count + CNT_W'(1);
endmodule

// File: tb/tb_stall_flush_ctrl.sv
// tb_stall_flush_ctrl: table-driven and sequence checks of stall_flush_ctrl at default and long-stall parameters
module tb_stall_flush_ctrl;
  localparam logic [31:0] ADD = 32'h0020_8133;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LUI = 32'h0000_82B7;
  localparam logic [31:0] SW  = 32'h0032_2023;
  localparam logic [31:0] ADI = 32'h0033_0293;
  localparam logic [31:0] JAL = 32'h0001_806F;
  localparam logic [7:0] O_RUN = 8'hF0, O_LU = 8'h36, O_FRZ = 8'h02, O_RED = 8'hFD, O_FL = 8'hF9, O_RST = 8'h0C;
  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        mr, bd;
    logic [1:0]  br;
    logic        busy, clr;
    logic [7:0]  eo;
    logic [15:0] ec;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] inst = NOP;
  logic [4:0] rd = 5'd0;
  logic mr = 1'b0, bd = 1'b0, busy = 1'b0, clr = 1'b0;
  logic [1:0] br = 2'b00;
  logic pc_a, fe_a, de_a, em_a, fr_a, dr_a, sd_a, fd_a;
  logic pc_b, fe_b, de_b, em_b, fr_b, dr_b, sd_b, fd_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;
  logic [7:0] outs_a, outs_b;
  int n_vec = 0, n_bad = 0;
  vec_t tab[$];
  assign outs_a = {pc_a, fe_a, de_a, em_a, fr_a, dr_a, sd_a, fd_a};
  assign outs_b = {pc_b, fe_b, de_b, em_b, fr_b, dr_b, sd_b, fd_b};
  always #5 clk = ~clk;
  stall_flush_ctrl u_a (
    .clk(clk), .rst(rst), .Inst(inst), .Rd_EX(rd), .MemRead_EX(mr), .Br_Detected(bd),
    .Br_result(br), .Dmem_Busy(busy), .Perf_Clr(clr), .PC_Fetch_EN(pc_a), .FE_DE_Reg_EN(fe_a),
    .DE_EX_Reg_EN(de_a), .EX_MEM_Reg_EN(em_a), .FE_DE_Reg_RST(fr_a), .DE_EX_Reg_RST(dr_a),
    .Stall_Detected(sd_a), .Flush_Detected(fd_a), .Stall_Count(cnt_a)
  );
  stall_flush_ctrl #(.LU_STALL_CYCLES(3), .BR_FLUSH_CYCLES(2), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .Inst(inst), .Rd_EX(rd), .MemRead_EX(mr), .Br_Detected(bd),
    .Br_result(br), .Dmem_Busy(busy), .Perf_Clr(clr), .PC_Fetch_EN(pc_b), .FE_DE_Reg_EN(fe_b),
    .DE_EX_Reg_EN(de_b), .EX_MEM_Reg_EN(em_b), .FE_DE_Reg_RST(fr_b), .DE_EX_Reg_RST(dr_b),
    .Stall_Detected(sd_b), .Flush_Detected(fd_b), .Stall_Count(cnt_b)
  );
  function automatic vec_t mk(logic [31:0] i, logic [4:0] r, logic m, logic d, logic [1:0] b,
                              logic bs, logic c, logic [7:0] eo, logic [15:0] ec);
    vec_t v;
    v = '{i, r, m, d, b, bs, c, eo, ec};
    return v;
  endfunction
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(logic [31:0] i, logic [4:0] r, logic m, logic d, logic [1:0] b, logic bs, logic c);
    inst = i; rd = r; mr = m; bd = d; br = b; busy = bs; clr = c;
  endtask
  task automatic sb(string nm, logic [31:0] i, logic [4:0] r, logic m, logic d, logic [1:0] b,
                    logic bs, logic c, logic [7:0] eo, logic [3:0] ec);
    drive(i, r, m, d, b, bs, c);
    @(negedge clk);
    chk({nm, " outs"}, {8'h0, outs_b}, {8'h0, eo});
    chk({nm, " cnt"}, {12'h0, cnt_b}, {12'h0, ec});
    @(posedge clk); #1;
  endtask
  initial begin
    tab.push_back(mk(NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 16'd0));
    tab.push_back(mk(ADD, 5'd1, 1, 0, 2'b00, 0, 0, O_LU,  16'd0));
    tab.push_back(mk(ADD, 5'd1, 0, 0, 2'b00, 0, 0, O_RUN, 16'd1));
    tab.push_back(mk(LUI, 5'd1, 1, 0, 2'b00, 0, 0, O_RUN, 16'd1));
    tab.push_back(mk(ADD, 5'd0, 1, 0, 2'b00, 0, 0, O_RUN, 16'd1));
    tab.push_back(mk(ADD, 5'd2, 1, 0, 2'b00, 0, 0, O_LU,  16'd1));
    tab.push_back(mk(SW,  5'd3, 1, 0, 2'b00, 0, 0, O_LU,  16'd2));
    tab.push_back(mk(ADI, 5'd3, 1, 0, 2'b00, 0, 0, O_RUN, 16'd3));
    tab.push_back(mk(JAL, 5'd3, 1, 0, 2'b00, 0, 0, O_RUN, 16'd3));
    tab.push_back(mk(ADD, 5'd1, 1, 1, 2'b01, 0, 0, O_RED, 16'd3));
    tab.push_back(mk(ADD, 5'd1, 0, 1, 2'b00, 0, 0, O_RUN, 16'd3));
    tab.push_back(mk(NOP, 5'd0, 0, 0, 2'b10, 0, 0, O_RUN, 16'd3));
    tab.push_back(mk(NOP, 5'd0, 0, 0, 2'b00, 1, 0, O_FRZ, 16'd3));
    tab.push_back(mk(NOP, 5'd0, 0, 1, 2'b11, 1, 0, O_FRZ, 16'd4));
    tab.push_back(mk(NOP, 5'd0, 0, 1, 2'b11, 0, 0, O_RED, 16'd5));
    tab.push_back(mk(NOP, 5'd0, 0, 0, 2'b00, 1, 1, O_FRZ, 16'd5));
    tab.push_back(mk(NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 16'd0));
    tab.push_back(mk(NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 16'd0));
    @(negedge clk);
    chk("rst outs a", {8'h0, outs_a}, {8'h0, O_RST});
    chk("rst cnt a", cnt_a, 16'd0);
    chk("rst outs b", {8'h0, outs_b}, {8'h0, O_RST});
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (tab[k]) begin
      drive(tab[k].inst, tab[k].rd, tab[k].mr, tab[k].bd, tab[k].br, tab[k].busy, tab[k].clr);
      @(negedge clk);
      chk($sformatf("vec%0d outs", k), {8'h0, outs_a}, {8'h0, tab[k].eo});
      chk($sformatf("vec%0d cnt", k), cnt_a, tab[k].ec);
      @(posedge clk); #1;
    end
    drive(NOP, 5'd0, 0, 0, 2'b00, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2 outs b", {8'h0, outs_b}, {8'h0, O_RST});
    chk("rst2 cnt b", {12'h0, cnt_b}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb("lu3 c0", ADD, 5'd1, 1, 0, 2'b00, 0, 0, O_LU,  4'd0);
    sb("lu3 c1", ADD, 5'd1, 0, 0, 2'b00, 0, 0, O_LU,  4'd1);
    sb("lu3 c2", NOP, 5'd0, 0, 0, 2'b00, 1, 0, O_FRZ, 4'd2);
    sb("lu3 c3", NOP, 5'd0, 0, 0, 2'b00, 1, 0, O_FRZ, 4'd3);
    sb("lu3 c4", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_LU,  4'd4);
    sb("lu3 c5", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 4'd5);
    sb("fl2 c0", NOP, 5'd0, 0, 1, 2'b01, 0, 0, O_RED, 4'd5);
    sb("fl2 c1", ADD, 5'd1, 1, 0, 2'b00, 0, 0, O_FL,  4'd5);
    sb("fl2 c2", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 4'd5);
    sb("fl2 nr", NOP, 5'd0, 0, 1, 2'b00, 0, 0, O_RUN, 4'd5);
    sb("pri c0", ADD, 5'd1, 1, 0, 2'b00, 0, 0, O_LU,  4'd5);
    sb("pri c1", NOP, 5'd0, 0, 1, 2'b11, 0, 0, O_RED, 4'd6);
    sb("pri c2", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_FL,  4'd6);
    sb("pri c3", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 4'd6);
    sb("pri c4", NOP, 5'd0, 0, 1, 2'b11, 1, 0, O_FRZ, 4'd6);
    sb("pri c5", NOP, 5'd0, 0, 1, 2'b11, 0, 0, O_RED, 4'd7);
    sb("pri c6", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_FL,  4'd7);
    sb("pri c7", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 4'd7);
    for (int i = 0; i < 10; i++)
      sb($sformatf("sat%0d", i), NOP, 5'd0, 0, 0, 2'b00, 1, 0, O_FRZ, (7 + i > 15) ? 4'd15 : 4'(7 + i));
    sb("sat hold", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 4'd15);
    sb("clr win",  NOP, 5'd0, 0, 0, 2'b00, 1, 1, O_FRZ, 4'd15);
    sb("clr done", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 4'd0);
    sb("rlu c0", ADD, 5'd1, 1, 0, 2'b00, 0, 0, O_LU, 4'd0);
    sb("rlu c1", ADD, 5'd1, 0, 0, 2'b00, 0, 0, O_LU, 4'd1);
    rst = 1'b1;
    #1;
    chk("rlu rst outs", {8'h0, outs_b}, {8'h0, O_RST});
    chk("rlu rst cnt", {12'h0, cnt_b}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb("rlu post", NOP, 5'd0, 0, 0, 2'b00, 0, 0, O_RUN, 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
